// File: rtl/ro_scan_controller.sv
// Ring-oscillator scan sequencer: steps tap/oscillator selects, runs a warm-up and a gate
// window, counts synchronised rising edges of the selected oscillator, and emits one record per point.
`timescale 1ns/1ps
module ro_scan_controller #(
    parameter int NUM_RO     = 10,
    parameter int NUM_TAPS   = 5,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 8,
    parameter int WARMUP_CYC = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                scan_go_i,
    input  logic [15:0]         gate_cyc_i,
    input  logic                ro_clk_i,
    output logic                ro_start_o,
    output logic [NUM_TAPS-1:0] tap_sel_o,
    output logic [3:0]          ro_sel_o,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [CNT_W+7:0]    res_data_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_WARMUP = 3'd2;
    localparam logic [2:0] S_GATE   = 3'd3;
    localparam logic [2:0] S_EMIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0]       RO_LAST     = 4'(NUM_RO - 1);
    localparam logic [2:0]       TAP_LAST    = 3'(NUM_TAPS - 1);
    localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0]      WARMUP_LAST = 16'(WARMUP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    function automatic logic [NUM_TAPS-1:0] tap_onehot(input logic [2:0] idx);
        logic [NUM_TAPS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            oh[i] = (idx == 3'(i));
        end
        return oh;
    endfunction

    logic [2:0]          state_q,     state_d;
    logic [2:0]          tap_q,       tap_d;
    logic [3:0]          ro_q,        ro_d;
    logic [15:0]         gate_q,      gate_d;
    logic [15:0]         cyc_q,       cyc_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                sat_q,       sat_d;
    logic [2:0]          sync_q,      sync_d;
    logic                ro_start_q,  ro_start_d;
    logic [NUM_TAPS-1:0] tap_sel_q,   tap_sel_d;
    logic [3:0]          ro_sel_q,    ro_sel_d;
    logic                res_valid_q, res_valid_d;
    logic [CNT_W+7:0]    res_data_q,  res_data_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    logic                edge_s;
    logic [CNT_W-1:0]    cnt_next_s;
    logic                sat_next_s;

    // Two synchroniser flops plus one history flop for rising-edge detection.
    always_comb begin
        sync_d = {sync_q[1:0], ro_clk_i};
        edge_s = sync_q[1] & ~sync_q[2];
    end

    // Saturating edge counter value including the edge seen this cycle.
    always_comb begin
        cnt_next_s = cnt_q;
        sat_next_s = sat_q;
        if (edge_s) begin
            if (cnt_q == CNT_MAX) begin
                sat_next_s = 1'b1;
            end else begin
                cnt_next_s = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_next_s = cnt_q;
        end
    end

    // Scan sequencer next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        ro_d        = ro_q;
        gate_d      = gate_q;
        cyc_d       = cyc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        ro_start_d  = ro_start_q;
        tap_sel_d   = tap_sel_q;
        ro_sel_d    = ro_sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (scan_go_i) begin
                    tap_d      = 3'd0;
                    ro_d       = 4'd0;
                    gate_d     = (gate_cyc_i == 16'd0) ? 16'd1 : gate_cyc_i;
                    cyc_d      = 16'd0;
                    busy_d     = 1'b1;
                    tap_sel_d  = tap_onehot(3'd0);
                    ro_sel_d   = 4'd0;
                    ro_start_d = 1'b0;
                    state_d    = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (cyc_q == SETTLE_LAST) begin
                    cyc_d      = 16'd0;
                    ro_start_d = 1'b1;
                    state_d    = S_WARMUP;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_WARMUP: begin
                if (cyc_q == WARMUP_LAST) begin
                    cyc_d   = 16'd0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = S_GATE;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_GATE: begin
                cnt_d = cnt_next_s;
                sat_d = sat_next_s;
                // The last gate cycle's edge is folded straight into the record.
                if (cyc_q == gate_q - 16'd1) begin
                    cyc_d       = 16'd0;
                    ro_start_d  = 1'b0;
                    res_valid_d = 1'b1;
                    res_data_d  = {sat_next_s, tap_q, ro_q, cnt_next_s};
                    state_d     = S_EMIT;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_EMIT: begin
                if (res_valid_q && res_ready_i) begin
                    res_valid_d = 1'b0;
                    if (ro_q != RO_LAST) begin
                        ro_d      = ro_q + 4'd1;
                        ro_sel_d  = ro_q + 4'd1;
                        tap_sel_d = tap_onehot(tap_q);
                        state_d   = S_SETTLE;
                    end else if (tap_q != TAP_LAST) begin
                        tap_d     = tap_q + 3'd1;
                        ro_d      = 4'd0;
                        ro_sel_d  = 4'd0;
                        tap_sel_d = tap_onehot(tap_q + 3'd1);
                        state_d   = S_SETTLE;
                    end else begin
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        tap_sel_d = '0;
                        state_d   = S_DONE;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                ro_start_d  = 1'b0;
                tap_sel_d   = '0;
                res_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            tap_q       <= 3'd0;
            ro_q        <= 4'd0;
            gate_q      <= 16'd0;
            cyc_q       <= 16'd0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            sync_q      <= 3'd0;
            ro_start_q  <= 1'b0;
            tap_sel_q   <= '0;
            ro_sel_q    <= 4'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            ro_q        <= ro_d;
            gate_q      <= gate_d;
            cyc_q       <= cyc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            sync_q      <= sync_d;
            ro_start_q  <= ro_start_d;
            tap_sel_q   <= tap_sel_d;
            ro_sel_q    <= ro_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ro_start_o  = ro_start_q;
    assign tap_sel_o   = tap_sel_q;
    assign ro_sel_o    = ro_sel_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
